tilemap_access_arbiter: RTL and testbench

- Shares one single-port synchronous tile-map RAM (the Bomberman grid: wall/brick/bomb/empty codes per tile) between two requesters.
- Requester 1 is the display renderer, which fetches tile codes for pixels in flight.
- Requester 2 is game logic, which reads and writes tiles.
- Display reads have absolute priority. Game writes can be held off until vertical blanking so a frame never shows a half-updated map.

---
 rtl/tilemap_pkg.sv | 39 +++
 rtl/tilemap_access_arbiter_if.sv | 36 +++
 rtl/tilemap_ram.sv | 28 ++
 rtl/tilemap_access_arbiter.sv | 139 +++++++++++++
 tb/tb_tilemap_access_arbiter.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/tilemap_pkg.sv
// Shared definitions for the tile-map access arbiter: tile codes, the game
// port state encoding and the tags that route RAM read data back to its owner.
package tilemap_pkg;

   localparam int TILE_W = 4;

   localparam logic [TILE_W-1:0] TILE_EMPTY = 4'd0;
   localparam logic [TILE_W-1:0] TILE_WALL  = 4'd1;
   localparam logic [TILE_W-1:0] TILE_BRICK = 4'd2;
   localparam logic [TILE_W-1:0] TILE_BOMB  = 4'd3;

   localparam int VCOUNT_W = 10;

   typedef enum logic [2:0] {
      G_IDLE = 3'd0,
      G_PEND = 3'd1,
      G_RD1  = 3'd2,
      G_RD2  = 3'd3,
      G_ACK  = 3'd4
   } g_state_t;

   typedef enum logic {
      SRC_DISP = 1'b0,
      SRC_GAME = 1'b1
   } src_t;

   // One stage of the read-return pipeline.
   typedef struct packed {
      logic valid;
      src_t src;
   } ret_tag_t;

   // True once the raster has left the visible area of the frame.
   function automatic logic is_vblank(input logic [VCOUNT_W-1:0] vcount,
                                      input int v_active);
      return (32'(vcount) >= 32'(v_active));
   endfunction

endpackage

// File: rtl/tilemap_access_arbiter_if.sv
// Requester-side bundle of the arbiter: the display read port and the game
// read/write port.
//
// Handshakes:
//   display: disp_req is a one-cycle pulse sampled with disp_addr; it is
//            always accepted. disp_valid pulses for one cycle when disp_data
//            holds the result, two cycles after the request edge, in order.
//   game:    gm_req is a level held (with gm_we/gm_addr/gm_wdata stable)
//            until gm_ack pulses for one cycle. For reads gm_rdata is valid
//            with gm_ack and holds until the next game read completes.
interface tilemap_access_arbiter_if #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 4
);
   logic              disp_req;
   logic [ADDR_W-1:0] disp_addr;
   logic              disp_valid;
   logic [DATA_W-1:0] disp_data;

   logic              gm_req;
   logic              gm_we;
   logic [ADDR_W-1:0] gm_addr;
   logic [DATA_W-1:0] gm_wdata;
   logic              gm_ack;
   logic [DATA_W-1:0] gm_rdata;

   modport master (
      output disp_req, disp_addr, gm_req, gm_we, gm_addr, gm_wdata,
      input  disp_valid, disp_data, gm_ack, gm_rdata
   );

   modport slave (
      input  disp_req, disp_addr, gm_req, gm_we, gm_addr, gm_wdata,
      output disp_valid, disp_data, gm_ack, gm_rdata
   );
endinterface

// File: rtl/tilemap_ram.sv
// Behavioural single-port synchronous tile-map RAM. Read data appears the
// cycle after the enabled edge and holds until the next enabled read.
module tilemap_ram #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 4
) (
   input  logic              clk,
   input  logic              en,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   // Single access per cycle: either write the tile or latch its code.
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            mem[addr] <= wdata;
         end else begin
            rdata <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/tilemap_access_arbiter.sv
// Shares one single-port tile-map RAM between the display renderer (absolute
// priority, reads only) and game logic (reads and writes, writes optionally
// deferred to vertical blanking so a frame never shows a half-updated map).
module tilemap_access_arbiter
   import tilemap_pkg::*;
#(
   parameter int ADDR_W       = 9,
   parameter int DATA_W       = 4,
   parameter int V_ACTIVE     = 480,
   parameter bit WR_IN_VBLANK = 1'b1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [VCOUNT_W-1:0] vCount,
   tilemap_access_arbiter_if.slave bus,
   output logic                ram_en,
   output logic                ram_we,
   output logic [ADDR_W-1:0]   ram_addr,
   output logic [DATA_W-1:0]   ram_wdata,
   input  logic [DATA_W-1:0]   ram_rdata,
   output logic                in_vblank,
   output g_state_t            gm_state_dbg
);

   logic              ram_en_q,     ram_en_d;
   logic              ram_we_q,     ram_we_d;
   logic [ADDR_W-1:0] ram_addr_q,   ram_addr_d;
   logic [DATA_W-1:0] ram_wdata_q,  ram_wdata_d;
   logic              in_vblank_q,  in_vblank_d;
   ret_tag_t          ret1_q,       ret1_d;
   ret_tag_t          ret2_q,       ret2_d;
   logic              disp_valid_q, disp_valid_d;
   logic [DATA_W-1:0] disp_data_q,  disp_data_d;
   logic              gm_ack_q,     gm_ack_d;
   logic [DATA_W-1:0] gm_rdata_q,   gm_rdata_d;
   g_state_t          g_state_q,    g_state_d;

   logic vblank_now;
   logic game_ok;
   logic game_grant;

   // Slot arbitration: display first, then a pending game op if permitted.
   // Write permission looks at the live vCount so a held write goes out on
   // the very first edge that samples a blanking line (the same value that
   // in_vblank takes on that edge).
   always_comb begin
      vblank_now  = is_vblank(vCount, V_ACTIVE);
      in_vblank_d = vblank_now;
      game_ok     = !bus.gm_we || (WR_IN_VBLANK == 1'b0) || vblank_now;
      game_grant  = !bus.disp_req && (g_state_q == G_PEND) && game_ok;

      ram_en_d    = 1'b0;
      ram_we_d    = 1'b0;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      if (bus.disp_req) begin
         ram_en_d   = 1'b1;
         ram_addr_d = bus.disp_addr;
      end else if (game_grant) begin
         ram_en_d    = 1'b1;
         ram_we_d    = bus.gm_we;
         ram_addr_d  = bus.gm_addr;
         ram_wdata_d = bus.gm_wdata;
      end
   end

   // Return pipeline: tag each read with its owner, then steer ram_rdata
   // two edges after the slot was registered.
   always_comb begin
      ret1_d.valid = bus.disp_req || (game_grant && !bus.gm_we);
      ret1_d.src   = bus.disp_req ? SRC_DISP : SRC_GAME;
      ret2_d       = ret1_q;

      disp_valid_d = ret2_q.valid && (ret2_q.src == SRC_DISP);
      disp_data_d  = disp_valid_d ? ram_rdata : disp_data_q;
      gm_rdata_d   = (ret2_q.valid && (ret2_q.src == SRC_GAME)) ? ram_rdata : gm_rdata_q;
   end

   // Game port FSM; the ack is registered on the edge that leaves G_ACK, so
   // a still-high gm_req is never re-accepted on that same edge.
   always_comb begin
      g_state_d = g_state_q;
      gm_ack_d  = 1'b0;
      case (g_state_q)
         G_IDLE: if (bus.gm_req) g_state_d = G_PEND;
         G_PEND: if (game_grant) g_state_d = bus.gm_we ? G_ACK : G_RD1;
         G_RD1:  g_state_d = G_RD2;
         G_RD2:  g_state_d = G_ACK;
         G_ACK: begin
            gm_ack_d  = 1'b1;
            g_state_d = G_IDLE;
         end
         default: g_state_d = G_IDLE;
      endcase
   end

   // All state; reset drops in-flight reads and pending game ops at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ram_en_q     <= 1'b0;
         ram_we_q     <= 1'b0;
         ram_addr_q   <= '0;
         ram_wdata_q  <= '0;
         in_vblank_q  <= 1'b0;
         ret1_q       <= '0;
         ret2_q       <= '0;
         disp_valid_q <= 1'b0;
         disp_data_q  <= TILE_EMPTY;
         gm_ack_q     <= 1'b0;
         gm_rdata_q   <= TILE_EMPTY;
         g_state_q    <= G_IDLE;
      end else begin
         ram_en_q     <= ram_en_d;
         ram_we_q     <= ram_we_d;
         ram_addr_q   <= ram_addr_d;
         ram_wdata_q  <= ram_wdata_d;
         in_vblank_q  <= in_vblank_d;
         ret1_q       <= ret1_d;
         ret2_q       <= ret2_d;
         disp_valid_q <= disp_valid_d;
         disp_data_q  <= disp_data_d;
         gm_ack_q     <= gm_ack_d;
         gm_rdata_q   <= gm_rdata_d;
         g_state_q    <= g_state_d;
      end
   end

   assign ram_en         = ram_en_q;
   assign ram_we         = ram_we_q;
   assign ram_addr       = ram_addr_q;
   assign ram_wdata      = ram_wdata_q;
   assign in_vblank      = in_vblank_q;
   assign bus.disp_valid = disp_valid_q;
   assign bus.disp_data  = disp_data_q;
   assign bus.gm_ack     = gm_ack_q;
   assign bus.gm_rdata   = gm_rdata_q;
   assign gm_state_dbg   = g_state_q;

endmodule

// File: tb/tb_tilemap_access_arbiter.sv
// Directed bench for tilemap_access_arbiter. Instance A defers game writes to
// vertical blanking, instance B lets them through on any idle cycle. Each
// arbiter drives its own behavioural RAM preloaded with code = addr & 0xF.
// Inputs change 1 ns after a rising edge; outputs are checked at that point.
module tb_tilemap_access_arbiter;
   import tilemap_pkg::*;

   localparam int ADDR_W = 9;
   localparam int DATA_W = 4;

   logic                clk = 1'b0;
   logic                reset = 1'b1;
   logic [VCOUNT_W-1:0] vCount = '0;

   logic              a_ram_en, a_ram_we, a_in_vblank;
   logic [ADDR_W-1:0] a_ram_addr;
   logic [DATA_W-1:0] a_ram_wdata, a_ram_rdata;
   g_state_t          a_state;

   logic              b_ram_en, b_ram_we, b_in_vblank;
   logic [ADDR_W-1:0] b_ram_addr;
   logic [DATA_W-1:0] b_ram_wdata, b_ram_rdata;
   g_state_t          b_state;

   int vectors = 0;
   int miscompares = 0;
   logic we_seen;

   tilemap_access_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_a ();
   tilemap_access_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_b ();

   tilemap_access_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .V_ACTIVE(480), .WR_IN_VBLANK(1'b1)
   ) u_dut_a (
      .clk(clk), .reset(reset), .vCount(vCount), .bus(bus_a),
      .ram_en(a_ram_en), .ram_we(a_ram_we), .ram_addr(a_ram_addr),
      .ram_wdata(a_ram_wdata), .ram_rdata(a_ram_rdata),
      .in_vblank(a_in_vblank), .gm_state_dbg(a_state)
   );

   tilemap_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram_a (
      .clk(clk), .en(a_ram_en), .we(a_ram_we), .addr(a_ram_addr),
      .wdata(a_ram_wdata), .rdata(a_ram_rdata)
   );

   tilemap_access_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .V_ACTIVE(480), .WR_IN_VBLANK(1'b0)
   ) u_dut_b (
      .clk(clk), .reset(reset), .vCount(vCount), .bus(bus_b),
      .ram_en(b_ram_en), .ram_we(b_ram_we), .ram_addr(b_ram_addr),
      .ram_wdata(b_ram_wdata), .ram_rdata(b_ram_rdata),
      .in_vblank(b_in_vblank), .gm_state_dbg(b_state)
   );

   tilemap_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram_b (
      .clk(clk), .en(b_ram_en), .we(b_ram_we), .addr(b_ram_addr),
      .wdata(b_ram_wdata), .rdata(b_ram_rdata)
   );

   // 100 MHz clock.
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      bus_a.disp_req = 1'b0; bus_a.disp_addr = '0;
      bus_a.gm_req = 1'b0; bus_a.gm_we = 1'b0; bus_a.gm_addr = '0; bus_a.gm_wdata = '0;
      bus_b.disp_req = 1'b0; bus_b.disp_addr = '0;
      bus_b.gm_req = 1'b0; bus_b.gm_we = 1'b0; bus_b.gm_addr = '0; bus_b.gm_wdata = '0;
      for (int i = 0; i < 2**ADDR_W; i++) begin
         u_ram_a.mem[i] = 4'(i);
         u_ram_b.mem[i] = 4'(i);
      end

      // Reset state.
      tick(); tick();
      chk("rst_ram_en", a_ram_en, 0);
      chk("rst_disp_valid", bus_a.disp_valid, 0);
      chk("rst_gm_ack", bus_a.gm_ack, 0);
      chk("rst_state", a_state, G_IDLE);
      reset = 1'b0;
      tick();

      // Back-to-back display reads of 5, 6, 7.
      bus_a.disp_req = 1'b1; bus_a.disp_addr = 9'd5;
      tick();
      chk("d1_ram_en", a_ram_en, 1);
      chk("d1_ram_addr", a_ram_addr, 5);
      bus_a.disp_addr = 9'd6;
      tick();
      bus_a.disp_addr = 9'd7;
      tick();
      chk("d1_valid0", bus_a.disp_valid, 1);
      chk("d1_data0", bus_a.disp_data, 5);
      bus_a.disp_req = 1'b0;
      tick();
      chk("d1_valid1", bus_a.disp_valid, 1);
      chk("d1_data1", bus_a.disp_data, 6);
      tick();
      chk("d1_valid2", bus_a.disp_valid, 1);
      chk("d1_data2", bus_a.disp_data, 7);
      tick();
      chk("d1_valid_end", bus_a.disp_valid, 0);

      // Game read of address 10, no display traffic.
      vCount = 10'd100;
      bus_a.gm_req = 1'b1; bus_a.gm_we = 1'b0; bus_a.gm_addr = 9'd10;
      tick();
      chk("gr_pend", a_state, G_PEND);
      chk("gr_no_en", a_ram_en, 0);
      tick();
      chk("gr_ram_en", a_ram_en, 1);
      chk("gr_ram_we", a_ram_we, 0);
      chk("gr_ram_addr", a_ram_addr, 10);
      chk("gr_rd1", a_state, G_RD1);
      tick();
      chk("gr_ack_early1", bus_a.gm_ack, 0);
      tick();
      chk("gr_ack_early2", bus_a.gm_ack, 0);
      chk("gr_rdata", bus_a.gm_rdata, 10);
      chk("gr_in_vblank", a_in_vblank, 0);
      tick();
      chk("gr_ack", bus_a.gm_ack, 1);
      bus_a.gm_req = 1'b0;
      tick();
      chk("gr_ack_once", bus_a.gm_ack, 0);

      // Game write held until vertical blanking.
      bus_a.gm_req = 1'b1; bus_a.gm_we = 1'b1; bus_a.gm_addr = 9'd3; bus_a.gm_wdata = TILE_BRICK;
      tick();
      we_seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (a_ram_we) we_seen = 1'b1;
      end
      chk("gw_held_no_we", we_seen, 0);
      chk("gw_held_pend", a_state, G_PEND);
      vCount = 10'd480;
      tick();
      chk("gw_ram_en", a_ram_en, 1);
      chk("gw_ram_we", a_ram_we, 1);
      chk("gw_ram_addr", a_ram_addr, 3);
      chk("gw_ram_wdata", a_ram_wdata, TILE_BRICK);
      chk("gw_in_vblank", a_in_vblank, 1);
      tick();
      chk("gw_ack", bus_a.gm_ack, 1);
      bus_a.gm_req = 1'b0; bus_a.gm_we = 1'b0;
      vCount = 10'd100;
      bus_a.disp_req = 1'b1; bus_a.disp_addr = 9'd3;
      tick();
      bus_a.disp_req = 1'b0;
      tick(); tick();
      chk("gw_readback_valid", bus_a.disp_valid, 1);
      chk("gw_readback_data", bus_a.disp_data, TILE_BRICK);

      // Write during active video with writes allowed any time (instance B).
      bus_b.gm_req = 1'b1; bus_b.gm_we = 1'b1; bus_b.gm_addr = 9'd4; bus_b.gm_wdata = TILE_BOMB;
      tick();
      tick();
      chk("bw_ram_we", b_ram_we, 1);
      chk("bw_ram_addr", b_ram_addr, 4);
      chk("bw_ram_wdata", b_ram_wdata, TILE_BOMB);
      chk("bw_in_vblank", b_in_vblank, 0);
      tick();
      chk("bw_ack", bus_b.gm_ack, 1);
      bus_b.gm_req = 1'b0; bus_b.gm_we = 1'b0;
      bus_b.disp_req = 1'b1; bus_b.disp_addr = 9'd4;
      tick();
      bus_b.disp_req = 1'b0;
      tick(); tick();
      chk("bw_readback_valid", bus_b.disp_valid, 1);
      chk("bw_readback_data", bus_b.disp_data, TILE_BOMB);

      // Display and eligible game read on the same edge.
      bus_a.gm_req = 1'b1; bus_a.gm_we = 1'b0; bus_a.gm_addr = 9'd20;
      tick();
      bus_a.disp_req = 1'b1; bus_a.disp_addr = 9'd30;
      tick();
      chk("col_disp_addr", a_ram_addr, 30);
      chk("col_game_waits", a_state, G_PEND);
      bus_a.disp_req = 1'b0;
      tick();
      chk("col_game_addr", a_ram_addr, 20);
      chk("col_game_rd1", a_state, G_RD1);
      tick();
      chk("col_disp_valid", bus_a.disp_valid, 1);
      chk("col_disp_data", bus_a.disp_data, 30 & 15);
      chk("col_gm_rdata_hold", bus_a.gm_rdata, 10);
      tick();
      chk("col_gm_rdata", bus_a.gm_rdata, 20 & 15);
      chk("col_no_disp_valid", bus_a.disp_valid, 0);
      tick();
      chk("col_gm_ack", bus_a.gm_ack, 1);
      bus_a.gm_req = 1'b0;
      tick();

      // Reset while a game read sits in G_RD1 and a display read is in flight.
      bus_a.gm_req = 1'b1; bus_a.gm_we = 1'b0; bus_a.gm_addr = 9'd40;
      bus_a.disp_req = 1'b1; bus_a.disp_addr = 9'd50;
      tick();
      bus_a.disp_req = 1'b0;
      tick();
      chk("mr_in_rd1", a_state, G_RD1);
      reset = 1'b1;
      #1;
      chk("mr_ram_en", a_ram_en, 0);
      chk("mr_ram_addr", a_ram_addr, 0);
      chk("mr_disp_data", bus_a.disp_data, 0);
      chk("mr_gm_rdata", bus_a.gm_rdata, 0);
      chk("mr_state", a_state, G_IDLE);
      tick(); tick();
      chk("mr_no_valid", bus_a.disp_valid, 0);
      chk("mr_no_ack", bus_a.gm_ack, 0);
      reset = 1'b0;
      tick();
      chk("mr_restart_pend", a_state, G_PEND);
      chk("mr_valid_after", bus_a.disp_valid, 0);
      tick();
      chk("mr_restart_addr", a_ram_addr, 40);
      chk("mr_restart_rd1", a_state, G_RD1);
      tick();
      chk("mr_ack_early", bus_a.gm_ack, 0);
      chk("mr_valid_late", bus_a.disp_valid, 0);
      tick();
      chk("mr_rdata", bus_a.gm_rdata, 40 & 15);
      tick();
      chk("mr_ack", bus_a.gm_ack, 1);
      bus_a.gm_req = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
